data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//   Shares the single data-memory port between two masters:
//     - CPU: the pipeline MEM stage (address, write data, read, write).
//     - DBG: the debug/loader port.
//   Each access runs as a request/ack transaction on the slave side.
//   The block stalls the pipeline until the CPU access completes and aborts hung slave accesses with a timeout.
//   Sits between the pipelined datapath's bAddr/bWData/MemRead/MemWrite/bRData pins and data RAM.
// PARAMETERS
//   RR       1    1: round-robin between CPU and DBG; 0: fixed CPU priority
//   TIMEOUT  255  max wait cycles for mem_ack before abort (>=1)
//   ERR_DATA 32'hDEAD_BEEF  read data returned on an aborted access
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   reset, asynchronous, ACTIVE-HIGH (name kept for codebase consistency)
//   cpu_addr   in   32  CPU byte address (ALU result in MEM stage)
//   cpu_wdata  in   32  CPU store data
//   cpu_rd     in   1   CPU load request
//   cpu_wr     in   1   CPU store request
//   cpu_rdata  out  32  load data, valid in CPU completion cycle
//   cpu_stall  out  1   hold IF..MEM pipeline registers
//   dbg_addr   in   32  debug address
//   dbg_wdata  in   32  debug write data
//   dbg_req    in   1   debug request, held until dbg_ack
//   dbg_we     in   1   1 = write, 0 = read
//   dbg_rdata  out  32  debug read data, valid when dbg_ack=1
//   dbg_ack    out  1   one-cycle completion strobe
//   mem_addr   out  32  slave address (registered)
//   mem_wdata  out  32  slave write data (registered)
//   mem_rd     out  1   slave read strobe, held until ack or abort
//   mem_wr     out  1   slave write strobe, held until ack or abort
//   mem_rdata  in   32  slave read data, valid with mem_ack
//   mem_ack    in   1   slave completion
//   bus_err    out  1   sticky timeout flag
// BEHAVIOUR
//   - Reset: async assert forces, immediately:
//       - state=IDLE, last_grant=DBG, timer=0
//       - mem_addr/mem_wdata/mem_rd/mem_wr=0, bus_err=0
//     An in-flight transfer is abandoned. No dbg_ack is issued.
//   - States: IDLE, CPU_XFER, DBG_XFER.
//   - Request definitions:
//       - cpu_req = cpu_rd|cpu_wr
//       - If cpu_rd and cpu_wr are both high, the access is a write.
//   - IDLE:
//       - If exactly one request is pending, grant that master.
//       - If both are pending: with RR=1, grant the master != last_grant; with RR=0, grant CPU.
//       - On grant, register addr/wdata/op into mem_*, clear timer, enter *_XFER.
//       - mem_ack in IDLE is ignored.
//   - *_XFER: mem_rd/mem_wr stay high; the timer increments each cycle without ack.
//       - mem_ack=1: completion.
//           - Drop mem_rd/mem_wr.
//           - Set last_grant to the served master.
//           - Return to IDLE.
//       - timer==TIMEOUT-1 and no ack: abort.
//           - Handled as a completion; read data is ERR_DATA.
//           - bus_err set to 1 until reset.
//   - Completion outputs (combinational, completion cycle only, else 0):
//       - CPU: cpu_rdata = mem_rdata (or ERR_DATA on abort).
//       - DBG: dbg_ack=1, dbg_rdata likewise.
//   - cpu_stall = cpu_req & ~(state==CPU_XFER & completing). This holds through reset and whenever DBG owns the bus.
//   - Latency: request in cycle N is driven on the slave in N+1. Zero-wait slave: ack in N+1, so 1 stall cycle per CPU access.
//   - After completion the arbiter is in IDLE. A request still high next cycle is a NEW transaction: the pipeline has advanced, and DBG must drop dbg_req on seeing dbg_ack.
//   - The request inputs are not re-sampled during *_XFER; registered mem_* values are authoritative.
// STRUCTURE
//   - Package mem_arb_pkg holds:
//       - state enum {IDLE, CPU_XFER, DBG_XFER}
//       - master id encoding (CPU=0, DBG=1)
//       - ERR_DATA default
//   - Sub-module bus_wait_timer: clear/enable/expire counter, width $clog2(TIMEOUT+1).
//   - Top holds the FSM, grant logic, slave registers and completion muxing.
// TESTING
//   1. Reset asserted mid CPU_XFER -> mem_rd=0 same cycle, state IDLE, bus_err=0, no dbg_ack.
//   2. CPU load, addr 0x40, slave acks 1 cycle later with 0x1234 -> cpu_stall high 1 cycle, cpu_rdata=0x1234 in ack cycle.
//   3. RR=1, CPU and DBG request together from reset, 3 back-to-back ops each -> grants alternate CPU,DBG,CPU,DBG...
//   4. RR=0, same stimulus -> all CPU ops first, then DBG; cpu_stall high while DBG owns the bus.
//   5. TIMEOUT=4, slave never acks CPU load -> abort after 4 wait cycles, cpu_rdata=0xDEADBEEF, bus_err=1 until reset.
//   6. DBG write 0xCAFE to 0x80, 3 wait states -> mem_wr high 4 cycles, mem_addr=0x80, one dbg_ack pulse; dbg_req dropped -> no second write.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    DBG_XFER = 2'd2
  } state_t;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DBG = 1'b1
  } master_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - wait-cycle counter that flags a hung slave access
module bus_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - CPU/debug arbiter for the single data-memory port
module data_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit          RR       = 1'b1,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  state_t      state, state_nxt;
  master_t     last_grant;
  logic        cpu_req, xfer, expire, completing, abort;
  logic        grant_cpu, grant_dbg;
  logic [31:0] done_data;

  assign cpu_req    = cpu_rd | cpu_wr;
  assign xfer       = (state != IDLE);
  assign completing = xfer & (mem_ack | expire);
  assign abort      = xfer & ~mem_ack & expire;
  assign done_data  = abort ? ERR_DATA : mem_rdata;
  assign cpu_stall  = cpu_req & ~((state == CPU_XFER) & completing);

  bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst_n),
    .clr    (grant_cpu | grant_dbg),
    .en     (xfer & ~completing),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Round-robin only breaks ties; a lone requester is always served.
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    cpu_rdata = '0;
    dbg_rdata = '0;
    dbg_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && (!dbg_req || (RR == 1'b0) || (last_grant == M_DBG))) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_XFER;
        end else if (dbg_req) begin
          grant_dbg = 1'b1;
          state_nxt = DBG_XFER;
        end
      end
      CPU_XFER: begin
        if (completing) begin
          state_nxt = IDLE;
          cpu_rdata = done_data;
        end
      end
      DBG_XFER: begin
        if (completing) begin
          state_nxt = IDLE;
          dbg_ack   = 1'b1;
          dbg_rdata = done_data;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A simultaneous read+write from the CPU is issued as a write.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      last_grant <= M_DBG;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_wr    <= cpu_wr;
        mem_rd    <= cpu_rd & ~cpu_wr;
      end else if (grant_dbg) begin
        mem_addr  <= dbg_addr;
        mem_wdata <= dbg_wdata;
        mem_wr    <= dbg_we;
        mem_rd    <= ~dbg_we;
      end else if (completing) begin
        mem_rd     <= 1'b0;
        mem_wr     <= 1'b0;
        last_grant <= (state == CPU_XFER) ? M_CPU : M_DBG;
      end
      if (abort) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  op;
  } xact_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cpu_addr[2], cpu_wdata[2], cpu_rdata[2];
  logic [31:0] dbg_addr[2], dbg_wdata[2], dbg_rdata[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
  logic        cpu_rd[2], cpu_wr[2], cpu_stall[2];
  logic        dbg_req[2], dbg_we[2], dbg_ack[2];
  logic        mem_rd[2], mem_wr[2], mem_ack[2], bus_err[2];

  int          checks = 0;
  int          errors = 0;
  int          wait_fixed[2];
  int          wcnt[2], cur_wait[2];
  bit          use_fixed;
  logic [31:0] fixed_rdata;
  xact_t       slog[$];

  data_bus_arbiter #(.RR(1'b1), .TIMEOUT(4)) u_rr (
    .clk(clk), .rst_n(rst),
    .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
    .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]), .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]),
    .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
    .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]), .bus_err(bus_err[0])
  );

  data_bus_arbiter #(.RR(1'b0), .TIMEOUT(4)) u_fp (
    .clk(clk), .rst_n(rst),
    .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
    .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]), .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]),
    .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
    .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]), .bus_err(bus_err[1])
  );

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Slave: acks after cur_wait wait states (-1 never acks, -2 picks 0..2 per access).
  initial begin
    for (int d = 0; d < 2; d++) begin
      mem_ack[d] = 1'b0; mem_rdata[d] = '0; wcnt[d] = 0; cur_wait[d] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (mem_rd[d] || mem_wr[d]) begin
          if (wcnt[d] == 0)
            cur_wait[d] = (wait_fixed[d] == -2) ? int'($urandom_range(0, 2)) : wait_fixed[d];
          if (cur_wait[d] >= 0 && wcnt[d] == cur_wait[d]) begin
            xact_t x;
            mem_ack[d]   = 1'b1;
            mem_rdata[d] = use_fixed ? fixed_rdata : rd_fn(mem_addr[d]);
            x.addr = mem_addr[d]; x.data = mem_wdata[d]; x.op = {mem_wr[d], mem_rd[d]};
            slog.push_back(x);
          end else begin
            mem_ack[d]   = 1'b0;
            mem_rdata[d] = $urandom;
          end
          wcnt[d]++;
        end else begin
          mem_ack[d] = 1'b0; mem_rdata[d] = '0; wcnt[d] = 0;
        end
      end
    end
  end

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      cpu_addr[d] = '0; cpu_wdata[d] = '0; cpu_rd[d] = 1'b0; cpu_wr[d] = 1'b0;
      dbg_addr[d] = '0; dbg_wdata[d] = '0; dbg_req[d] = 1'b0; dbg_we[d] = 1'b0;
      wait_fixed[d] = 0;
    end
    use_fixed = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    slog.delete();
  endtask

  task automatic test_reset();
    int n;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({mem_rd[0], mem_wr[0], bus_err[0], dbg_ack[0]} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {mem_rd[0], mem_wr[0], bus_err[0], dbg_ack[0]});
    end
    checks++; if ({mem_addr[0], mem_wdata[0]} !== 64'h0) begin
      errors++; $display("FAIL reset_regs: got %h expected 0", {mem_addr[0], mem_wdata[0]});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_fixed[0] = -1;
    cpu_addr[0] = 32'h100; cpu_rd[0] = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (mem_rd[0] !== 1'b1) begin
      errors++; $display("FAIL reset_pre_xfer: mem_rd got %b expected 1", mem_rd[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if ({mem_rd[0], mem_addr[0], dbg_ack[0], bus_err[0], cpu_stall[0]} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_mid_xfer: rd/addr/ack/err/stall got %b %h %b %b %b expected 0 0 0 0 1",
                         mem_rd[0], mem_addr[0], dbg_ack[0], bus_err[0], cpu_stall[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0; cpu_rd[0] = 1'b0; wait_fixed[0] = 0;
    dbg_addr[0] = 32'h200; dbg_we[0] = 1'b0; dbg_req[0] = 1'b1;
    n = 0;
    while (dbg_ack[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n !== 2) begin
      errors++; $display("FAIL reset_idle_after: dbg_ack at cycle %0d expected 2", n);
    end
    @(posedge clk); #1;
    dbg_req[0] = 1'b0;
  endtask

  task automatic test_cpu_load();
    do_reset();
    use_fixed = 1'b1; fixed_rdata = 32'h1234;
    cpu_addr[0] = 32'h40; cpu_rd[0] = 1'b1;
    @(negedge clk);
    checks++; if ({cpu_stall[0], mem_rd[0], cpu_rdata[0]} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL load_req_cycle: stall/rd/rdata got %b %b %h expected 1 0 0", cpu_stall[0], mem_rd[0], cpu_rdata[0]);
    end
    @(negedge clk);
    checks++; if ({cpu_stall[0], mem_rd[0], mem_addr[0]} !== {1'b0, 1'b1, 32'h40}) begin
      errors++; $display("FAIL load_ack_cycle: stall/rd/addr got %b %b %h expected 0 1 40", cpu_stall[0], mem_rd[0], mem_addr[0]);
    end
    checks++; if (cpu_rdata[0] !== 32'h1234) begin
      errors++; $display("FAIL load_rdata: got %h expected 00001234", cpu_rdata[0]);
    end
    @(posedge clk); #1;
    cpu_rd[0] = 1'b0;
    @(negedge clk);
    checks++; if ({mem_rd[0], cpu_rdata[0]} !== 33'h0) begin
      errors++; $display("FAIL load_after: rd/rdata got %b %h expected 0 0", mem_rd[0], cpu_rdata[0]);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_arbitration(input int d, input bit rr);
    logic [31:0] ca[3], cw[3], da[3], dw[3], r;
    logic [1:0]  cop[3];
    logic        dwe[3];
    xact_t       exp_q[$];
    xact_t       x;
    int          nc, nd;
    bit          last_dbg;
    do_reset();
    wait_fixed[d] = -2;
    for (int i = 0; i < 3; i++) begin
      r = $urandom; ca[i] = {1'b0, r[30:2], 2'b00};
      r = $urandom; da[i] = {1'b1, r[30:2], 2'b00};
      cw[i] = $urandom; dw[i] = $urandom;
      case ($urandom_range(0, 2))
        0:       cop[i] = 2'b01;
        1:       cop[i] = 2'b10;
        default: cop[i] = 2'b11;
      endcase
      dwe[i] = 1'($urandom_range(0, 1));
    end
    nc = 0; nd = 0; last_dbg = 1'b1;
    while (nc < 3 || nd < 3) begin
      bit pick_dbg;
      if (nc < 3 && nd < 3) pick_dbg = rr ? !last_dbg : 1'b0;
      else                  pick_dbg = (nc >= 3);
      if (pick_dbg) begin
        x.addr = da[nd]; x.data = dw[nd]; x.op = dwe[nd] ? 2'b10 : 2'b01; nd++;
      end else begin
        x.addr = ca[nc]; x.data = cw[nc]; x.op = cop[nc][1] ? 2'b10 : 2'b01; nc++;
      end
      exp_q.push_back(x);
      last_dbg = pick_dbg;
    end
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int n; bit done;
          cpu_addr[d] = ca[i]; cpu_wdata[d] = cw[i]; cpu_rd[d] = cop[i][0]; cpu_wr[d] = cop[i][1];
          n = 0; done = 1'b0;
          while (!done && n < 100) begin
            @(negedge clk); n++;
            if ((mem_rd[d] || mem_wr[d]) && mem_addr[d][31]) begin
              checks++; if (cpu_stall[d] !== 1'b1) begin
                errors++; $display("FAIL arb%0d_stall_dbg: cpu_stall got %b expected 1", d, cpu_stall[d]);
              end
            end
            if (cpu_stall[d] === 1'b0) begin
              done = 1'b1;
              if (!cop[i][1]) begin
                checks++; if (cpu_rdata[d] !== rd_fn(ca[i])) begin
                  errors++; $display("FAIL arb%0d_cpu_rdata: got %h expected %h", d, cpu_rdata[d], rd_fn(ca[i]));
                end
              end
            end
          end
          checks++; if (!done) begin
            errors++; $display("FAIL arb%0d_cpu_timeout: op %0d got no completion expected one", d, i);
          end
          @(posedge clk); #1;
        end
        cpu_rd[d] = 1'b0; cpu_wr[d] = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) begin
          int n; bit done;
          dbg_addr[d] = da[i]; dbg_wdata[d] = dw[i]; dbg_we[d] = dwe[i]; dbg_req[d] = 1'b1;
          n = 0; done = 1'b0;
          while (!done && n < 100) begin
            @(negedge clk); n++;
            if (dbg_ack[d] === 1'b1) begin
              done = 1'b1;
              if (!dwe[i]) begin
                checks++; if (dbg_rdata[d] !== rd_fn(da[i])) begin
                  errors++; $display("FAIL arb%0d_dbg_rdata: got %h expected %h", d, dbg_rdata[d], rd_fn(da[i]));
                end
              end
            end
          end
          checks++; if (!done) begin
            errors++; $display("FAIL arb%0d_dbg_timeout: op %0d got no ack expected one", d, i);
          end
          @(posedge clk); #1;
        end
        dbg_req[d] = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    checks++; if (slog.size() !== 6) begin
      errors++; $display("FAIL arb%0d_count: got %0d accesses expected 6", d, slog.size());
    end
    for (int k = 0; k < 6 && k < slog.size(); k++) begin
      checks++; if ({slog[k].addr, slog[k].data, slog[k].op} !== {exp_q[k].addr, exp_q[k].data, exp_q[k].op}) begin
        errors++; $display("FAIL arb%0d_order[%0d]: got %h/%h/%b expected %h/%h/%b", d, k,
                           slog[k].addr, slog[k].data, slog[k].op, exp_q[k].addr, exp_q[k].data, exp_q[k].op);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, n; bit done; logic [31:0] r;
    do_reset();
    wait_fixed[0] = -1;
    r = $urandom; cpu_addr[0] = {r[31:2], 2'b00}; cpu_rd[0] = 1'b1;
    cyc = 0; n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk); n++;
      if (mem_rd[0] === 1'b1) cyc++;
      if (cpu_stall[0] === 1'b0) begin
        done = 1'b1;
        checks++; if (cpu_rdata[0] !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL timeout_rdata: got %h expected deadbeef", cpu_rdata[0]);
        end
      end
    end
    checks++; if (!done || cyc != 4) begin
      errors++; $display("FAIL timeout_cycles: done=%0d wait cycles got %0d expected 4", done, cyc);
    end
    @(posedge clk); #1;
    cpu_rd[0] = 1'b0;
    @(negedge clk);
    checks++; if ({bus_err[0], mem_rd[0]} !== 2'b10) begin
      errors++; $display("FAIL timeout_err_set: err/rd got %b %b expected 1 0", bus_err[0], mem_rd[0]);
    end
    @(posedge clk); #1;
    wait_fixed[0] = 0;
    r = $urandom; cpu_addr[0] = {r[31:2], 2'b00}; cpu_rd[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_stall[0] !== 1'b0 && n < 10);
    checks++; if ({cpu_rdata[0], bus_err[0]} !== {rd_fn(cpu_addr[0]), 1'b1}) begin
      errors++; $display("FAIL timeout_sticky: rdata/err got %h %b expected %h 1", cpu_rdata[0], bus_err[0], rd_fn(cpu_addr[0]));
    end
    do_reset();
    @(negedge clk);
    checks++; if (bus_err[0] !== 1'b0) begin
      errors++; $display("FAIL timeout_err_clear: got %b expected 0", bus_err[0]);
    end
  endtask

  task automatic test_dbg_write();
    int n, wr_cyc, acks, extra; bit bad_addr;
    do_reset();
    wait_fixed[0] = 3;
    dbg_addr[0] = 32'h80; dbg_wdata[0] = 32'hCAFE; dbg_we[0] = 1'b1; dbg_req[0] = 1'b1;
    n = 0; wr_cyc = 0; acks = 0; bad_addr = 1'b0;
    while (acks == 0 && n < 20) begin
      @(negedge clk); n++;
      if (mem_wr[0] === 1'b1) begin
        wr_cyc++;
        if (mem_addr[0] !== 32'h80) bad_addr = 1'b1;
      end
      if (dbg_ack[0] === 1'b1) acks++;
    end
    checks++; if (wr_cyc != 4 || acks != 1) begin
      errors++; $display("FAIL dbgwr_strobe: wr cycles/acks got %0d/%0d expected 4/1", wr_cyc, acks);
    end
    checks++; if (bad_addr) begin
      errors++; $display("FAIL dbgwr_addr: got %h expected 00000080", mem_addr[0]);
    end
    @(posedge clk); #1;
    dbg_req[0] = 1'b0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (dbg_ack[0] !== 1'b0 || mem_wr[0] !== 1'b0) extra++;
    end
    checks++; if (extra != 0) begin
      errors++; $display("FAIL dbgwr_no_repeat: extra ack/write cycles got %0d expected 0", extra);
    end
    checks++; if (slog.size() != 1 || slog[0].data !== 32'hCAFE || slog[0].op !== 2'b10) begin
      errors++; $display("FAIL dbgwr_slave: accesses %0d first data %h expected 1 0000cafe",
                         slog.size(), (slog.size() > 0) ? slog[0].data : 32'h0);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cpu_load();
    test_arbitration(0, 1'b1);
    test_arbitration(1, 1'b0);
    test_timeout();
    test_dbg_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
